macguffin_crypt_pipe: RTL and testbench
=======================================

MACGUFFIN_CRYPT_PIPE -- requirements
Module: macguffin_crypt_pipe

Interface
REQ-001 SHALL have parameter ROUND_NUM, default 32, total cipher rounds.
REQ-002 SHALL have parameter BLOCK_SIZE, default 64, block width in bits.
REQ-003 SHALL have parameter ROUNDS_PER_STAGE, default 1, rounds computed combinationally per pipeline stage; legal values divide ROUND_NUM; STAGES = ROUND_NUM/ROUNDS_PER_STAGE.
REQ-004 SHALL have parameter USER_WIDTH, default 8, sideband width carried alongside each block.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset; assertion clears state immediately, release synchronous to clk.
REQ-007 round_keys  input  ROUND_NUM x (BLOCK_SIZE*3/4)  round key array, index 0 = first encryption round.
REQ-008 flush  input  1  synchronous pipeline clear.
REQ-009 s_axis_tdata/tvalid/tready/tlast/tuser  in/in/out/in/in  BLOCK_SIZE/1/1/1/USER_WIDTH  slave AXI4-Stream.
REQ-010 s_axis_tmode  input  1  per-beat mode: 0 = encrypt, 1 = decrypt.
REQ-011 m_axis_tdata/tvalid/tready/tlast/tuser  out/out/in/out/out  BLOCK_SIZE/1/1/1/USER_WIDTH  master AXI4-Stream.
REQ-012 occupancy  output  $clog2(STAGES+1)  count of valid stages.
REQ-013 busy  output  1  high when occupancy != 0.

Function
REQ-014 Pipeline SHALL have STAGES registered slots, each holding valid, data, tlast, tuser, mode.
REQ-015 Slot s SHALL apply rounds s*ROUNDS_PER_STAGE .. (s+1)*ROUNDS_PER_STAGE-1 of the sequence to its registered data; output of slot STAGES-1 drives m_axis_tdata combinationally.
REQ-016 Encrypt beats SHALL use round_keys[k] for sequence round k and the MacGuffin forward round.
REQ-017 Decrypt beats SHALL use round_keys[ROUND_NUM-1-k] for sequence round k and the MacGuffin inverse round; decrypt(encrypt(P)) = P for identical keys.
REQ-018 Mode SHALL travel with its beat; encrypt and decrypt beats SHALL interleave freely with no bubbles.
REQ-019 Slot move rule: last slot moves when not valid or m_axis_tready; slot s moves when not valid or slot s+1 moves.
REQ-020 s_axis_tready SHALL equal move of slot 0; a beat is accepted when s_axis_tvalid & s_axis_tready.
REQ-021 Empty slots SHALL be filled by the next move, collapsing bubbles.
REQ-022 Latency from acceptance to m_axis_tvalid SHALL be STAGES cycles with m_axis_tready held high; throughput one block per cycle.
REQ-023 m_axis_tdata/tlast/tuser SHALL remain stable while m_axis_tvalid & !m_axis_tready.
REQ-024 tlast, tuser SHALL pass through unmodified and in order.
REQ-025 occupancy SHALL update each cycle: +1 on accept, -1 on output handshake, unchanged when both or neither.
REQ-026 flush=1 SHALL clear all valid bits at the next edge, take priority over accept, and drive s_axis_tready low in that cycle; occupancy becomes 0.
REQ-027 round_keys SHALL be held stable by the user while busy=1; behaviour otherwise undefined.

Reset
REQ-028 rst=0 SHALL asynchronously clear all valid bits, data, tlast, tuser, mode and occupancy to 0.
REQ-029 During and after reset: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tuser=0, busy=0, occupancy=0; s_axis_tready=1 from first cycle after release.
REQ-030 Reset mid-operation SHALL discard all in-flight beats; none appear at output after release.

Verification
REQ-031 Encrypt: ROUND_NUM=32, RPS=1, key schedule of key 0, P=0x0000000000000000, tready=1 -> output equals golden model ciphertext after exactly 32 cycles.
REQ-032 Round trip: stream 100 random blocks encrypt, feed outputs back with tmode=1 -> original blocks, tuser/tlast preserved, in order.
REQ-033 Backpressure: fill with 32 beats, m_axis_tready=0 for 10 cycles -> occupancy=32, s_axis_tready=0, output stable; release -> 32 beats out back-to-back.
REQ-034 Interleave: alternating tmode 0/1 beats, random tready 50% -> all results match model, no loss or duplication.
REQ-035 Flush with occupancy=17 -> next cycle occupancy=0, m_axis_tvalid=0, no stale output.
REQ-036 Assert rst low mid-stream with 20 beats in flight -> outputs cleared asynchronously, none emerge after release; repeat RPS=4 (latency 8).

Source files
------------

// File: rtl/macguffin_crypt_pipe.sv
// MacGuffin-style block cipher pipeline: unbalanced Feistel rounds (one 16-bit word keyed by the other three),
// with an elastic AXI4-Stream slot pipeline that carries a per-beat encrypt/decrypt mode.
module macguffin_crypt_pipe #(
    parameter int ROUND_NUM        = 32,
    parameter int BLOCK_SIZE       = 64,
    parameter int ROUNDS_PER_STAGE = 1,
    parameter int USER_WIDTH       = 8,
    localparam int STAGES = ROUND_NUM / ROUNDS_PER_STAGE,
    localparam int KEY_W  = BLOCK_SIZE * 3 / 4,
    localparam int OCC_W  = $clog2(STAGES + 1)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [ROUND_NUM-1:0][KEY_W-1:0] round_keys,
    input  logic                            flush,
    input  logic [BLOCK_SIZE-1:0]           s_axis_tdata,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic                            s_axis_tlast,
    input  logic [USER_WIDTH-1:0]           s_axis_tuser,
    input  logic                            s_axis_tmode,
    output logic [BLOCK_SIZE-1:0]           m_axis_tdata,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic                            m_axis_tlast,
    output logic [USER_WIDTH-1:0]           m_axis_tuser,
    output logic [OCC_W-1:0]                occupancy,
    output logic                            busy
);
    localparam int W    = BLOCK_SIZE / 4;
    localparam int KI_W = (ROUND_NUM > 1) ? $clog2(ROUND_NUM) : 1;

    typedef logic [BLOCK_SIZE-1:0] blk_t;
    typedef logic [KEY_W-1:0]      key_t;
    typedef logic [W-1:0]          word_t;
    typedef logic [USER_WIDTH-1:0] user_t;

    localparam logic [3:0] SBOX [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                         4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

    // Keyed mixing of the three control words into a 16-bit mask for the target word.
    function automatic word_t f_mix(word_t b, word_t c, word_t d, key_t k);
        word_t m, x, y;
        m = (c ^ k[2*W-1 -: W]) & ~(d ^ k[W-1:0]);
        x = (b ^ k[3*W-1 -: W]) ^ {m[W-2:0], m[W-1]};
        y = '0;
        for (int n = 0; n < W / 4; n++) y[4*n +: 4] = SBOX[x[4*n +: 4]];
        return y ^ {y[W-5:0], y[W-1 -: 4]};
    endfunction

    // Forward: target word a absorbs f(b,c,d), then words rotate left. Inverse undoes exactly that.
    function automatic blk_t round_fn(blk_t blk, key_t k, logic inv);
        word_t a, b, c, d;
        {a, b, c, d} = blk;
        if (!inv) return {b, c, d, a ^ f_mix(b, c, d, k)};
        else      return {d ^ f_mix(a, b, c, k), a, b, c};
    endfunction

    logic  valid_q [STAGES];
    blk_t  data_q  [STAGES];
    logic  last_q  [STAGES];
    user_t user_q  [STAGES];
    logic  mode_q  [STAGES];
    blk_t  stage_out [STAGES];
    logic [STAGES-1:0] valid_vec;
    logic [STAGES-1:0] move;
    logic accept, out_hs;

    for (genvar s = 0; s < STAGES; s++) begin : g_slot
        blk_t             acc;
        logic [KI_W-1:0]  key_idx;
        blk_t             in_data;
        logic             in_valid, in_last, in_mode;
        user_t            in_user;

        assign valid_vec[s] = valid_q[s];
        // A slot may advance if it or any slot downstream of it is empty, or the sink is taking a beat.
        assign move[s] = ~(&valid_vec[STAGES-1:s]) | m_axis_tready;

        // NOTE: temporaries are assigned before use on every path, so this block stays purely combinational.
        always_comb begin
            acc     = data_q[s];
            key_idx = '0;
            for (int r = 0; r < ROUNDS_PER_STAGE; r++) begin
                key_idx = KI_W'(mode_q[s] ? ROUND_NUM - 1 - (s * ROUNDS_PER_STAGE + r)
                                          : s * ROUNDS_PER_STAGE + r);
                acc = round_fn(acc, round_keys[key_idx], mode_q[s]);
            end
        end
        assign stage_out[s] = acc;

        if (s == 0) begin : g_head
            assign in_valid = s_axis_tvalid;
            assign in_data  = s_axis_tdata;
            assign in_last  = s_axis_tlast;
            assign in_user  = s_axis_tuser;
            assign in_mode  = s_axis_tmode;
        end else begin : g_body
            assign in_valid = valid_q[s-1];
            assign in_data  = stage_out[s-1];
            assign in_last  = last_q[s-1];
            assign in_user  = user_q[s-1];
            assign in_mode  = mode_q[s-1];
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                valid_q[s] <= 1'b0;
                data_q[s]  <= '0;
                last_q[s]  <= 1'b0;
                user_q[s]  <= '0;
                mode_q[s]  <= 1'b0;
            end else if (flush) begin
                valid_q[s] <= 1'b0;
            end else if (move[s]) begin
                valid_q[s] <= in_valid;
                data_q[s]  <= in_data;
                last_q[s]  <= in_last;
                user_q[s]  <= in_user;
                mode_q[s]  <= in_mode;
            end
        end
    end

    assign s_axis_tready = move[0] & ~flush;
    assign accept        = s_axis_tvalid & s_axis_tready;
    assign out_hs        = m_axis_tvalid & m_axis_tready;

    assign m_axis_tdata  = stage_out[STAGES-1];
    assign m_axis_tvalid = valid_q[STAGES-1];
    assign m_axis_tlast  = last_q[STAGES-1];
    assign m_axis_tuser  = user_q[STAGES-1];
    assign busy          = (occupancy != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                   occupancy <= '0;
        else if (flush)             occupancy <= '0;
        else if (accept && !out_hs) occupancy <= occupancy + OCC_W'(1);
        else if (!accept && out_hs) occupancy <= occupancy - OCC_W'(1);
    end
endmodule

// File: tb/tb_macguffin_crypt_pipe.sv
// Randomized bench for macguffin_crypt_pipe: a word-level cipher model plus a FIFO scoreboard of expected beats.
`timescale 1ns/1ps
module tb_macguffin_crypt_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0][47:0] keys;

    // Main DUT: one round per stage (32 stages).
    logic        rst, flush;
    logic [63:0] s_data, m_data;
    logic        s_valid, s_ready, s_last, s_mode;
    logic [7:0]  s_user, m_user;
    logic        m_valid, m_ready, m_last, busy;
    logic [5:0]  occ;

    // Second DUT: four rounds per stage (8 stages).
    logic        rst4, flush4;
    logic [63:0] s4_data, m4_data;
    logic        s4_valid, s4_ready, s4_last, s4_mode;
    logic [7:0]  s4_user, m4_user;
    logic        m4_valid, m4_ready, m4_last, busy4;
    logic [3:0]  occ4;

    macguffin_crypt_pipe u_dut (
        .clk(clk), .rst(rst), .round_keys(keys), .flush(flush),
        .s_axis_tdata(s_data), .s_axis_tvalid(s_valid), .s_axis_tready(s_ready),
        .s_axis_tlast(s_last), .s_axis_tuser(s_user), .s_axis_tmode(s_mode),
        .m_axis_tdata(m_data), .m_axis_tvalid(m_valid), .m_axis_tready(m_ready),
        .m_axis_tlast(m_last), .m_axis_tuser(m_user), .occupancy(occ), .busy(busy));

    macguffin_crypt_pipe #(.ROUNDS_PER_STAGE(4)) u_dut4 (
        .clk(clk), .rst(rst4), .round_keys(keys), .flush(flush4),
        .s_axis_tdata(s4_data), .s_axis_tvalid(s4_valid), .s_axis_tready(s4_ready),
        .s_axis_tlast(s4_last), .s_axis_tuser(s4_user), .s_axis_tmode(s4_mode),
        .m_axis_tdata(m4_data), .m_axis_tvalid(m4_valid), .m_axis_tready(m4_ready),
        .m_axis_tlast(m4_last), .m_axis_tuser(m4_user), .occupancy(occ4), .busy(busy4));

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    localparam logic [3:0] SBOX_REF [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                             4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

    function automatic logic [15:0] f_ref(logic [15:0] b, logic [15:0] c, logic [15:0] d, logic [47:0] k);
        logic [15:0] m, x, y;
        m = (c ^ k[31:16]) & ~(d ^ k[15:0]);
        x = (b ^ k[47:32]) ^ ((m << 1) | (m >> 15));
        for (int n = 0; n < 4; n++) y[4*n +: 4] = SBOX_REF[x[4*n +: 4]];
        return y ^ ((y << 4) | (y >> 12));
    endfunction

    function automatic logic [63:0] cipher_ref(logic [63:0] blk, logic dec);
        logic [15:0] w [4];
        logic [15:0] t;
        for (int i = 0; i < 4; i++) w[i] = blk[63-16*i -: 16];
        for (int r = 0; r < 32; r++) begin
            if (!dec) begin
                t = w[0] ^ f_ref(w[1], w[2], w[3], keys[r]);
                w[0] = w[1]; w[1] = w[2]; w[2] = w[3]; w[3] = t;
            end else begin
                t = w[3] ^ f_ref(w[0], w[1], w[2], keys[31-r]);
                w[3] = w[2]; w[2] = w[1]; w[1] = w[0]; w[0] = t;
            end
        end
        return {w[0], w[1], w[2], w[3]};
    endfunction

    function automatic void key_sched(logic [63:0] key);
        logic [63:0] h;
        for (int i = 0; i < 32; i++) begin
            h = key ^ (64'h9E3779B97F4A7C15 * 64'(i + 1));
            h = h ^ (h >> 29);
            h = h * 64'hBF58476D1CE4E5B9;
            h = h ^ (h >> 32);
            keys[i] = h[47:0];
        end
    endfunction

    // ---------------- scoreboard ----------------
    logic [72:0] exp_q [$];   // {last, user, data}
    logic [72:0] cap_q [$];
    bit cap_en = 0;
    int rdy_mode = 0;         // 0: always ready, 1: random, 2: stalled

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = 1'($urandom_range(0, 1));
            default: m_ready = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) check("spurious_out", 1, 0);
            else check("out_beat", {m_last, m_user, m_data}, exp_q.pop_front());
            if (cap_en) cap_q.push_back({m_last, m_user, m_data});
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [63:0] d, input logic mode, input logic last,
                        input logic [7:0] user, input logic [72:0] exp_beat);
        bit done = 0;
        s_data = d; s_mode = mode; s_last = last; s_user = user; s_valid = 1'b1;
        for (int t = 0; t < 2000 && !done; t++) begin
            @(negedge clk);
            if (s_ready) begin
                exp_q.push_back(exp_beat);
                done = 1;
            end
            step();
        end
        if (!done) check("send_timeout", 0, 1);
    endtask

    task automatic drain(input string tag);
        for (int t = 0; t < 3000 && exp_q.size() != 0; t++) @(posedge clk);
        #1;
        check({"drain_", tag}, exp_q.size(), 0);
    endtask

    task automatic set_ready_mode(input int mode);
        @(negedge clk);
        rdy_mode = mode;
        step();
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    logic [63:0] pt [100];
    logic        pl [100];
    logic [7:0]  pu [100];

    initial begin
        int lat, n, leaked;
        logic [63:0] d;
        logic [72:0] c;

        rst = 0; rst4 = 0; flush = 0; flush4 = 0;
        s_valid = 0; s_data = '0; s_last = 0; s_user = '0; s_mode = 0;
        s4_valid = 0; s4_data = '0; s4_last = 0; s4_user = '0; s4_mode = 0; m4_ready = 1;
        m_ready = 1;
        key_sched(64'h0);

        repeat (3) @(posedge clk);
        #1;
        check("rst_m_valid", m_valid, 0);
        check("rst_m_last", m_last, 0);
        check("rst_m_user", m_user, 0);
        check("rst_busy", busy, 0);
        check("rst_occ", occ, 0);
        rst = 1; rst4 = 1;
        @(negedge clk);
        check("rst_s_ready", s_ready, 1);
        step();

        // Single zero block, key 0 schedule: golden ciphertext and 32-cycle latency.
        send(64'h0, 1'b0, 1'b1, 8'hA5, {1'b1, 8'hA5, cipher_ref(64'h0, 1'b0)});
        s_valid = 0;
        lat = 1;
        while (!m_valid && lat < 200) begin step(); lat++; end
        check("enc_latency", lat, 32);
        check("golden_ct", m_data, cipher_ref(64'h0, 1'b0));
        drain("golden");

        // Round trip: 100 random blocks encrypted, outputs fed back for decryption.
        key_sched({$urandom, $urandom});
        set_ready_mode(1);
        cap_en = 1;
        for (int i = 0; i < 100; i++) begin
            pt[i] = {$urandom, $urandom};
            pl[i] = 1'($urandom_range(0, 1));
            pu[i] = 8'($urandom);
            send(pt[i], 1'b0, pl[i], pu[i], {pl[i], pu[i], cipher_ref(pt[i], 1'b0)});
        end
        s_valid = 0;
        drain("enc");
        cap_en = 0;
        check("cap_count", cap_q.size(), 100);
        for (int i = 0; i < 100 && i < cap_q.size(); i++) begin
            c = cap_q[i];
            send(c[63:0], 1'b1, c[72], c[71:64], {pl[i], pu[i], pt[i]});
        end
        s_valid = 0;
        drain("dec");

        // Alternating encrypt/decrypt beats under random backpressure.
        for (int i = 0; i < 200; i++) begin
            d = {$urandom, $urandom};
            c[71:64] = 8'(i);
            send(d, 1'(i), 1'(i % 7 == 0), c[71:64], {1'(i % 7 == 0), c[71:64], cipher_ref(d, 1'(i))});
        end
        s_valid = 0;
        drain("interleave");

        // Backpressure: fill all 32 slots, hold 10 cycles, then release.
        set_ready_mode(2);
        for (int i = 0; i < 32; i++) begin
            d = {$urandom, $urandom};
            send(d, 1'(i % 3 == 0), 1'b0, 8'(i), {1'b0, 8'(i), cipher_ref(d, 1'(i % 3 == 0))});
        end
        s_valid = 1;
        @(negedge clk);
        check("bp_occ", occ, 32);
        check("bp_s_ready", s_ready, 0);
        s_valid = 0;
        repeat (10) begin
            @(negedge clk);
            check("bp_hold", {m_valid, m_last, m_user, m_data}, {1'b1, exp_q[0]});
        end
        rdy_mode = 0;
        n = 0;
        for (int t = 0; t < 10 && !m_ready; t++) @(negedge clk);
        while (m_valid && n < 100) begin n++; @(negedge clk); end
        check("bp_burst", n, 32);
        drain("bp");

        // Flush with 17 beats in flight; beat offered during flush must be refused.
        set_ready_mode(2);
        for (int i = 0; i < 17; i++) send({$urandom, $urandom}, 1'b0, 1'b0, 8'h00, '0);
        s_valid = 0;
        @(negedge clk);
        check("flush_occ_before", occ, 17);
        step();
        flush = 1; s_valid = 1; s_data = {$urandom, $urandom};
        @(negedge clk);
        check("flush_s_ready", s_ready, 0);
        step();
        flush = 0; s_valid = 0;
        exp_q.delete();
        check("flush_occ_after", occ, 0);
        check("flush_m_valid", m_valid, 0);
        rdy_mode = 0;
        repeat (40) step();
        check("flush_busy", busy, 0);

        // Asynchronous reset with 20 beats in flight.
        set_ready_mode(2);
        for (int i = 0; i < 20; i++) send({$urandom, $urandom}, 1'b1, 1'b1, 8'hFF, '0);
        s_valid = 0;
        @(negedge clk);
        check("rst_occ_before", occ, 20);
        @(posedge clk); #3;
        rst = 0;
        #1;
        check("arst_m_valid", m_valid, 0);
        check("arst_occ", occ, 0);
        check("arst_busy", busy, 0);
        check("arst_tail", {m_last, m_user}, 0);
        exp_q.delete();
        step(); step();
        rst = 1;
        rdy_mode = 0;
        @(negedge clk);
        check("arst_s_ready", s_ready, 1);
        leaked = 0;
        repeat (50) begin @(negedge clk); if (m_valid) leaked++; end
        check("arst_leak", leaked, 0);

        // Four rounds per stage: latency 8, same ciphertext, then reset mid-stream.
        step();
        d = {$urandom, $urandom};
        s4_data = d; s4_mode = 0; s4_last = 1; s4_user = 8'h3C; s4_valid = 1; m4_ready = 1;
        @(negedge clk);
        check("rps4_s_ready", s4_ready, 1);
        step();
        s4_valid = 0;
        lat = 1;
        while (!m4_valid && lat < 100) begin step(); lat++; end
        check("rps4_latency", lat, 8);
        check("rps4_ct", {m4_last, m4_user, m4_data}, {1'b1, 8'h3C, cipher_ref(d, 1'b0)});
        step();
        m4_ready = 0;
        s4_valid = 1;
        for (int i = 0; i < 20; i++) begin s4_data = {$urandom, $urandom}; s4_mode = 1'(i); step(); end
        @(negedge clk);
        check("rps4_occ_full", occ4, 8);
        check("rps4_s_ready_full", s4_ready, 0);
        @(posedge clk); #3;
        rst4 = 0;
        #1;
        check("rps4_arst", {m4_valid, m4_last, m4_user, occ4, busy4}, 0);
        s4_valid = 0;
        step(); step();
        rst4 = 1; m4_ready = 1;
        leaked = 0;
        repeat (30) begin @(negedge clk); if (m4_valid) leaked++; end
        check("rps4_leak", leaked, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
